// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, the unpacked-operand view and the stage
// bundles of the add/sub alignment front end.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MAN_W   = 24;
  localparam int SHAMT_W = 5;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp_eff;
    logic [MAN_W-1:0] man;
  } fp_unp_t;

  typedef struct packed {
    logic [MAN_W-1:0]   man_big;
    logic [MAN_W-1:0]   man_small;
    logic [SHAMT_W-1:0] shamt;
    logic [EXP_W-1:0]   exp;
    logic               sign;
    logic               eff_sub;
    logic               nan;
    logic               inf;
  } fp_align_t;

  typedef struct packed {
    fp_align_t f;
    logic      sticky;
  } fp_out_t;

  // Denormals take exponent 1 with no hidden bit so they line up with the smallest normals.
  function automatic fp_unp_t fp_unpack(input logic sign, input logic [EXP_W+FRAC_W-1:0] mag);
    fp_unp_t u;
    u.sign    = sign;
    u.exp_eff = (mag[EXP_W+FRAC_W-1:FRAC_W] == 8'h00) ? 8'h01 : mag[EXP_W+FRAC_W-1:FRAC_W];
    u.man     = {(mag[EXP_W+FRAC_W-1:FRAC_W] != 8'h00), mag[FRAC_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_align_prep_if.sv
// Operand-in / aligned-bundle-out handshake bundle of fp_align_prep.
interface fp_align_prep_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_man_big;
  logic [23:0] out_man_small;
  logic [4:0]  out_shamt;
  logic        out_sticky;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_eff_sub;
  logic        out_nan;
  logic        out_inf;

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_man_big, out_man_small, out_shamt, out_sticky,
           out_exp, out_sign, out_eff_sub, out_nan, out_inf
  );

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_man_big, out_man_small, out_shamt, out_sticky,
           out_exp, out_sign, out_eff_sub, out_nan, out_inf
  );

endinterface

// File: rtl/fp_align_prep_sticky24.sv
// Sticky bit for a 24-bit right shift: OR of the bits shifted out.
module fp_sticky24
  import fp32_pkg::*;
(
  input  logic [MAN_W-1:0]   man,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               sticky
);

  logic [MAN_W-1:0] mask;

  // Shifts of 24 or more discard the whole mantissa.
  always_comb begin
    mask = {MAN_W{1'b0}};
    if (shamt >= SHAMT_W'(MAN_W)) begin
      mask = {MAN_W{1'b1}};
    end else begin
      mask = (MAN_W'(1) << shamt) - MAN_W'(1);
    end
  end

  assign sticky = |(man & mask);

endmodule

// File: rtl/fp_align_prep.sv
// Two-stage add/sub alignment front end: unpack and order by magnitude,
// then compute the sticky bit for the downstream 24-bit right shifter.
module fp_align_prep
  import fp32_pkg::*;
#(
  parameter int SHAMT_MAX = 31
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_align_prep_if.slave bus
);

  localparam logic [EXP_W-1:0]   SHAMT_LIM = EXP_W'(SHAMT_MAX);
  localparam logic [SHAMT_W-1:0] SHAMT_SAT = SHAMT_W'(SHAMT_MAX);

  fp_unp_t    a_u, b_u, big_u, small_u;
  logic       a_big, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_W-1:0] diff;
  fp_align_t  s1_calc;
  logic       s1_load, s2_load, sticky;

  logic      s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  fp_align_t s1_data_d, s1_data_q;
  fp_out_t   s2_data_d, s2_data_q;

  // Stage 1: B's sign is folded with the opcode so A-B is handled as A+(-B).
  always_comb begin
    a_u     = fp_unpack(bus.in_a[31], bus.in_a[30:0]);
    b_u     = fp_unpack(bus.in_b[31] ^ bus.in_op, bus.in_b[30:0]);
    a_big   = (bus.in_a[30:0] >= bus.in_b[30:0]);
    big_u   = a_u;
    small_u = b_u;
    if (a_big) begin
      big_u   = a_u;
      small_u = b_u;
    end else begin
      big_u   = b_u;
      small_u = a_u;
    end
    diff  = big_u.exp_eff - small_u.exp_eff;
    a_nan = (bus.in_a[30:23] == EXP_SPECIAL) && (bus.in_a[22:0] != 23'd0);
    b_nan = (bus.in_b[30:23] == EXP_SPECIAL) && (bus.in_b[22:0] != 23'd0);
    a_inf = (bus.in_a[30:23] == EXP_SPECIAL) && (bus.in_a[22:0] == 23'd0);
    b_inf = (bus.in_b[30:23] == EXP_SPECIAL) && (bus.in_b[22:0] == 23'd0);

    s1_calc.man_big   = big_u.man;
    s1_calc.man_small = small_u.man;
    s1_calc.shamt     = (diff > SHAMT_LIM) ? SHAMT_SAT : diff[SHAMT_W-1:0];
    s1_calc.exp       = big_u.exp_eff;
    s1_calc.sign      = big_u.sign;
    s1_calc.eff_sub   = a_u.sign ^ b_u.sign;
    s1_calc.nan       = a_nan | b_nan | (a_inf & b_inf & s1_calc.eff_sub);
    s1_calc.inf       = ~s1_calc.nan & (a_inf | b_inf);
  end

  fp_sticky24 u_sticky (
    .man    (s1_data_q.man_small),
    .shamt  (s1_data_q.shamt),
    .sticky (sticky)
  );

  // Pipeline control: each stage advances when it is empty or its consumer takes its contents.
  always_comb begin
    s2_load    = ~s2_valid_q | bus.out_ready;
    s1_load    = ~s1_valid_q | s2_load;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s1_load && bus.in_valid) begin
      s1_data_d = s1_calc;
    end else begin
      s1_data_d = s1_data_q;
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_load && s1_valid_q) begin
      s2_data_d = {s1_data_q, sticky};
    end else begin
      s2_data_d = s2_data_q;
    end
  end

  // Stage registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign bus.in_ready      = s1_load;
  assign bus.out_valid     = s2_valid_q;
  assign bus.out_man_big   = s2_data_q.f.man_big;
  assign bus.out_man_small = s2_data_q.f.man_small;
  assign bus.out_shamt     = s2_data_q.f.shamt;
  assign bus.out_sticky    = s2_data_q.sticky;
  assign bus.out_exp       = s2_data_q.f.exp;
  assign bus.out_sign      = s2_data_q.f.sign;
  assign bus.out_eff_sub   = s2_data_q.f.eff_sub;
  assign bus.out_nan       = s2_data_q.f.nan;
  assign bus.out_inf       = s2_data_q.f.inf;

endmodule
